mux4_rr_sched: RTL and testbench

- Round-robin scheduler that shares the 4:1 two-bit selector/display path between four requesters.
- Each requester owns the selector for a bounded dwell window.
- Drives the select code and one-hot grants, a registered data output and the 7-segment channel digit.
- Sits between four source channels (A..D, 2-bit each) and the board display/LED outputs.

---
 rtl/mux4_pkg.sv | 36 +++
 rtl/mux4_rr_sched_if.sv | 38 +++
 rtl/mux4_rr_sched_rr_pick4.sv | 34 +++
 rtl/mux4_rr_sched.sv | 121 ++++++++++++
 tb/tb_mux4_rr_sched.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/mux4_pkg.sv
// Shared types and constants for the mux4_rr_sched round-robin display scheduler.
//   state_e  : scheduler FSM states (idle arbitration / grant hold)
//   chan_t   : 2-bit channel index (0=A .. 3=D)
//   SEG_*    : 7-segment codes for channel digits and the idle dash
package mux4_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  typedef logic [1:0] chan_t;

  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Digit shown while a channel holds the selector.
  function automatic logic [6:0] seg_code(chan_t ch);
    logic [6:0] code;
    unique case (ch)
      2'd0:    code = SEG_0;
      2'd1:    code = SEG_1;
      2'd2:    code = SEG_2;
      default: code = SEG_3;
    endcase
    return code;
  endfunction

  function automatic logic [3:0] onehot4(chan_t ch);
    return 4'b0001 << ch;
  endfunction

endpackage

// File: rtl/mux4_rr_sched_if.sv
// Bundle of request/data inputs and grant/display outputs of mux4_rr_sched.
//   req      : per-channel request, bit0=A .. bit3=D
//   A..D     : 2-bit channel data
//   sel      : granted channel index (held when idle)
//   grant    : one-hot grant, zero when idle
//   dataout  : registered data of the granted channel
//   valid    : dataout carries granted data
//   done     : one-cycle pulse on the channel whose grant just ended
//   ds       : display digit enable (tied low)
//   seg7     : segment code of the granted index, dash when idle
// master: the side driving requests/data; slave: the scheduler.
interface mux4_rr_sched_if;
  import mux4_pkg::*;

  logic [3:0] req;
  logic [1:0] A;
  logic [1:0] B;
  logic [1:0] C;
  logic [1:0] D;
  chan_t      sel;
  logic [3:0] grant;
  logic [1:0] dataout;
  logic       valid;
  logic [3:0] done;
  logic       ds;
  logic [6:0] seg7;

  modport master (
    output req, A, B, C, D,
    input  sel, grant, dataout, valid, done, ds, seg7
  );

  modport slave (
    input  req, A, B, C, D,
    output sel, grant, dataout, valid, done, ds, seg7
  );

endinterface

// File: rtl/mux4_rr_sched_rr_pick4.sv
// Combinational round-robin picker for four requesters.
//   req_i  : request vector
//   last_i : most recently granted channel
//   pick_o : first requester found scanning last+1, last+2, ... modulo 4
//   any_o  : at least one request is present
module rr_pick4
  import mux4_pkg::*;
(
  input  logic [3:0] req_i,
  input  chan_t      last_i,
  output chan_t      pick_o,
  output logic       any_o
);

  chan_t cand;
  logic  found;

  always_comb begin
    pick_o = last_i;
    found  = 1'b0;
    cand   = last_i;
    // k=4 wraps back to last_i itself, so a sole requester can be re-granted.
    for (int k = 1; k <= 4; k++) begin
      cand = last_i + chan_t'(k);
      if (!found && req_i[cand]) begin
        pick_o = cand;
        found  = 1'b1;
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler sharing a 4:1 two-bit selector/display path.
// Each requesting channel holds the selector for up to DWELL cycles (less if it
// drops its request), followed by at least one idle cycle before the next grant.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : request/data inputs and registered grant/data/display outputs
module mux4_rr_sched
  import mux4_pkg::*;
#(
  parameter int unsigned DWELL = 8,
  parameter int unsigned CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  mux4_rr_sched_if.slave bus
);

  localparam logic [CNT_W-1:0] CntLoad = CNT_W'(DWELL - 1);

  state_e           state_q, state_d;
  logic [3:0]       grant_q, grant_d;
  chan_t            sel_q, sel_d;
  chan_t            last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       dataout_q, dataout_d;
  logic             valid_q, valid_d;
  logic [3:0]       done_q, done_d;
  logic [6:0]       seg7_q, seg7_d;

  logic [1:0] din [4];
  chan_t      pick;
  logic       any;

  assign din[0] = bus.A;
  assign din[1] = bus.B;
  assign din[2] = bus.C;
  assign din[3] = bus.D;

  rr_pick4 u_pick (
    .req_i  (bus.req),
    .last_i (last_q),
    .pick_o (pick),
    .any_o  (any)
  );

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    dataout_d = dataout_q;
    valid_d   = valid_q;
    seg7_d    = seg7_q;
    done_d    = 4'b0000;

    unique case (state_q)
      StIdle: begin
        // Pointer only moves here, on an actual grant.
        if (any) begin
          state_d   = StHold;
          grant_d   = onehot4(pick);
          sel_d     = pick;
          last_d    = pick;
          cnt_d     = CntLoad;
          valid_d   = 1'b1;
          dataout_d = din[pick];
          seg7_d    = seg_code(pick);
        end
      end
      StHold: begin
        // Early release and expiry share one release path; sel/last are kept.
        if ((cnt_q == '0) || !bus.req[sel_q]) begin
          state_d   = StIdle;
          grant_d   = 4'b0000;
          valid_d   = 1'b0;
          dataout_d = 2'b00;
          seg7_d    = SEG_DASH;
          done_d    = onehot4(sel_q);
        end else begin
          cnt_d     = cnt_q - 1'b1;
          dataout_d = din[sel_q];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 4'b0000;
      sel_q     <= 2'd0;
      last_q    <= 2'd3;
      cnt_q     <= '0;
      dataout_q <= 2'b00;
      valid_q   <= 1'b0;
      done_q    <= 4'b0000;
      seg7_q    <= SEG_DASH;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      dataout_q <= dataout_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      seg7_q    <= seg7_d;
    end
  end

  assign bus.sel     = sel_q;
  assign bus.grant   = grant_q;
  assign bus.dataout = dataout_q;
  assign bus.valid   = valid_q;
  assign bus.done    = done_q;
  assign bus.seg7    = seg7_q;
  assign bus.ds      = 1'b0;

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: stimulus pushes expected grants
// (channel, hold length) into a queue; a monitor pops one per grant it observes
// and checks sel/grant/seg7/dataout during the hold and the done pulse at release.
module tb_mux4_rr_sched;

  typedef struct {
    int ch;
    int len;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mux4_rr_sched_if u_if8 ();
  mux4_rr_sched_if u_if1 ();

  mux4_rr_sched #(.DWELL(8), .CNT_W(16)) u_dut8 (.clk(clk), .rst(rst), .bus(u_if8));
  mux4_rr_sched #(.DWELL(1), .CNT_W(4))  u_dut1 (.clk(clk), .rst(rst), .bus(u_if1));

  exp_t       q8[$];
  logic [3:0] q1[$];
  bit         run1 = 1'b0;
  int         n_cmp = 0;
  int         n_fail = 0;

  // Monitor state
  bit         in_g = 1'b0;
  int         hlen = 0;
  exp_t       cur;
  logic [1:0] prev_in [4];
  logic [3:0] g1;

  function automatic logic [6:0] seg_of(int ch);
    case (ch)
      0:       return 7'b0111111;
      1:       return 7'b0000110;
      2:       return 7'b1011011;
      default: return 7'b1001111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push8(input int ch, input int len);
    exp_t e;
    e.ch  = ch;
    e.len = len;
    q8.push_back(e);
  endtask

  // Monitor for the DWELL=8 instance.
  initial begin
    cur.ch  = 0;
    cur.len = 0;
    for (int i = 0; i < 4; i++) prev_in[i] = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_g = 1'b0;
      end else begin
        if (u_if8.valid && !in_g) begin
          if (q8.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_grant: got grant %0h expected none at %0t",
                     u_if8.grant, $time);
          end else begin
            cur = q8.pop_front();
          end
          in_g = 1'b1;
          hlen = 0;
        end
        if (u_if8.valid) begin
          hlen++;
          chk("hold_sel", 32'(u_if8.sel), 32'(cur.ch));
          chk("hold_grant", 32'(u_if8.grant), 32'(1) << cur.ch);
          chk("hold_seg7", 32'(u_if8.seg7), 32'(seg_of(cur.ch)));
          chk("hold_dataout", 32'(u_if8.dataout), 32'(prev_in[cur.ch]));
          chk("hold_done", 32'(u_if8.done), 32'(0));
        end else begin
          chk("idle_grant", 32'(u_if8.grant), 32'(0));
          chk("idle_dataout", 32'(u_if8.dataout), 32'(0));
          chk("idle_seg7", 32'(u_if8.seg7), 32'h40);
          if (in_g) begin
            chk("hold_len", 32'(hlen), 32'(cur.len));
            chk("done_pulse", 32'(u_if8.done), 32'(1) << cur.ch);
            in_g = 1'b0;
          end else begin
            chk("idle_done", 32'(u_if8.done), 32'(0));
          end
        end
      end
      prev_in[0] = u_if8.A;
      prev_in[1] = u_if8.B;
      prev_in[2] = u_if8.C;
      prev_in[3] = u_if8.D;
    end
  end

  // Monitor for the DWELL=1 instance: one expected grant word per cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (run1 && q1.size() > 0) begin
        g1 = q1.pop_front();
        chk("dwell1_grant", 32'(u_if1.grant), 32'(g1));
        chk("dwell1_valid", 32'(u_if1.valid), 32'(g1 != 4'b0000));
      end
    end
  end

  initial begin
    u_if8.req = 4'b0000;
    u_if8.A = 2'd0; u_if8.B = 2'd1; u_if8.C = 2'd2; u_if8.D = 2'd3;
    u_if1.req = 4'b0000;
    u_if1.A = 2'd0; u_if1.B = 2'd0; u_if1.C = 2'd0; u_if1.D = 2'd0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Idle after reset with no requests.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_grant", 32'(u_if8.grant), 32'(0));
      chk("rst_valid", 32'(u_if8.valid), 32'(0));
      chk("rst_seg7", 32'(u_if8.seg7), 32'h40);
      chk("rst_sel", 32'(u_if8.sel), 32'(0));
      chk("rst_ds", 32'(u_if8.ds), 32'(0));
    end

    // DWELL=1, req=1001: alternating single-cycle grants with gaps.
    q1.push_back(4'b0001); q1.push_back(4'b0000); q1.push_back(4'b1000); q1.push_back(4'b0000);
    q1.push_back(4'b0001); q1.push_back(4'b0000); q1.push_back(4'b1000); q1.push_back(4'b0000);
    @(posedge clk); #1 u_if1.req = 4'b1001;
    @(posedge clk); #1 run1 = 1'b1;
    repeat (8) @(posedge clk);
    #1 u_if1.req = 4'b0000;
    run1 = 1'b0;
    repeat (3) @(posedge clk);

    // All four requesting: 0,1,2,3,0, eight cycles each.
    push8(0, 8); push8(1, 8); push8(2, 8); push8(3, 8); push8(0, 8);
    @(posedge clk); #1 u_if8.req = 4'b1111;
    repeat (45) @(posedge clk);
    #1 u_if8.req = 4'b0000;
    repeat (3) @(posedge clk);

    // Sole requester 2: renewed after the one-cycle gap.
    push8(2, 8); push8(2, 8); push8(2, 8);
    @(posedge clk); #1 u_if8.req = 4'b0100;
    repeat (27) @(posedge clk);
    #1 u_if8.req = 4'b0000;
    repeat (3) @(posedge clk);

    // Channel 1 drops its request in its third hold cycle; channel 2 follows.
    push8(1, 3); push8(2, 8);
    @(posedge clk); #1 u_if8.req = 4'b0110;
    repeat (3) @(posedge clk);
    #1 u_if8.req = 4'b0100;
    repeat (10) @(posedge clk);
    #1 u_if8.req = 4'b0000;
    repeat (3) @(posedge clk);

    // Data changing during hold is tracked one cycle late.
    push8(0, 6);
    @(posedge clk); #1 u_if8.req = 4'b0001; u_if8.A = 2'd1;
    repeat (3) @(posedge clk);
    #1 u_if8.A = 2'd2;
    repeat (2) @(posedge clk);
    #1 u_if8.A = 2'd3;
    @(posedge clk);
    #1 u_if8.req = 4'b0000;
    repeat (3) @(posedge clk);
    u_if8.A = 2'd0;

    // Reset in the middle of channel 3's hold; then channel 0 goes first.
    push8(3, 0);
    @(posedge clk); #1 u_if8.req = 4'b1000;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_grant", 32'(u_if8.grant), 32'(0));
    chk("midrst_valid", 32'(u_if8.valid), 32'(0));
    chk("midrst_sel", 32'(u_if8.sel), 32'(0));
    chk("midrst_dataout", 32'(u_if8.dataout), 32'(0));
    chk("midrst_seg7", 32'(u_if8.seg7), 32'h40);
    chk("midrst_done", 32'(u_if8.done), 32'(0));
    @(posedge clk);
    push8(0, 8);
    #1 rst = 1'b0; u_if8.req = 4'b1111;
    repeat (9) @(posedge clk);
    #1 u_if8.req = 4'b0000;
    repeat (4) @(posedge clk);

    chk("queue8_drained", 32'(q8.size()), 32'(0));
    chk("queue1_drained", 32'(q1.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
